// File: rtl/game_state_controller_pkg.sv
// Shared definitions for the game state controller and the score/obstacle
// blocks that decode its state output.
package game_state_controller_pkg;

  // Game state encoding as seen on the gameState output
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_OVER = 2'b01,
    ST_RUN  = 2'b10
  } state_t;

  localparam int unsigned SPEED_W = 3;
  localparam logic [SPEED_W-1:0] SPEED_MAX = 3'd7;

  // Counter width able to hold 0..n-1, never less than one bit
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/game_state_controller_if.sv
// Player/game-side signal bundle of the game state controller.
//   jumpBtn    raw push-button, asynchronous to clk, active-high
//   collision  clk-synchronous collision flag
//   gameState  registered game state (IDLE 00, RUN 10, OVER 01)
//   scoreClk   registered divided clock for the score counter
//   jumpReq    one-cycle jump pulse for the dino sprite
//   speedLevel registered obstacle-speed index 0..7
interface game_state_controller_if;
  import game_state_controller_pkg::*;

  logic               jumpBtn;
  logic               collision;
  logic [1:0]         gameState;
  logic               scoreClk;
  logic               jumpReq;
  logic [SPEED_W-1:0] speedLevel;

  modport master (
    output jumpBtn, collision,
    input  gameState, scoreClk, jumpReq, speedLevel
  );

  modport slave (
    input  jumpBtn, collision,
    output gameState, scoreClk, jumpReq, speedLevel
  );

endinterface

// File: rtl/game_state_controller_btn_debounce.sv
// Push-button conditioner: 2-flop synchroniser, stable-level debouncer and
// rising-edge pulse of the accepted level.
//   clk, rst_n  system clock, asynchronous active-low reset
//   btn         raw asynchronous button
//   press       one-cycle pulse on each accepted 0->1 change
module btn_debounce
  import game_state_controller_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic press
);

  localparam int unsigned CNT_W = cnt_width(DEBOUNCE_CYC);

  logic             sync1;
  logic             sync2;
  logic             level;
  logic [CNT_W-1:0] cnt;

  // Accept a new level only after DEBOUNCE_CYC consecutive mismatching cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 != level) begin
        if (cnt == CNT_W'(DEBOUNCE_CYC - 1)) begin
          level <= sync2;
          cnt   <= '0;
          press <= sync2;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/game_state_controller.sv
// Game state controller: IDLE/RUN/OVER sequencing, score clock divider,
// jump request generation and obstacle speed levelling.
//   clk, rst_n  system clock, asynchronous active-low reset
//   gs          slave side of game_state_controller_if
module game_state_controller
  import game_state_controller_pkg::*;
#(
  parameter int unsigned TICK_DIV     = 10000000,
  parameter int unsigned DEBOUNCE_CYC = 1000000,
  parameter int unsigned LEVEL_TICKS  = 100
) (
  input logic                     clk,
  input logic                     rst_n,
  game_state_controller_if.slave  gs
);

  localparam int unsigned DIV_W = cnt_width(TICK_DIV);
  localparam int unsigned LVL_W = cnt_width(LEVEL_TICKS);

  logic btn_press;

  btn_debounce #(
    .DEBOUNCE_CYC (DEBOUNCE_CYC)
  ) u_btn_debounce (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (gs.jumpBtn),
    .press (btn_press)
  );

  // Free-running score divider; score_edge marks the first high cycle of scoreClk
  logic [DIV_W-1:0] div_cnt;
  logic             score_clk;
  logic             score_edge;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt    <= '0;
      score_clk  <= 1'b0;
      score_edge <= 1'b0;
    end else begin
      div_cnt    <= (div_cnt == DIV_W'(TICK_DIV - 1)) ? '0 : div_cnt + DIV_W'(1);
      score_clk  <= (div_cnt < DIV_W'(TICK_DIV / 2));
      score_edge <= (div_cnt == '0);
    end
  end

  state_t             state, state_n;
  logic               armed, armed_n;
  logic [LVL_W-1:0]   lvl_cnt, lvl_cnt_n;
  logic [SPEED_W-1:0] speed, speed_n;
  logic               jump_req, jump_req_n;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      armed    <= 1'b0;
      lvl_cnt  <= '0;
      speed    <= '0;
      jump_req <= 1'b0;
    end else begin
      state    <= state_n;
      armed    <= armed_n;
      lvl_cnt  <= lvl_cnt_n;
      speed    <= speed_n;
      jump_req <= jump_req_n;
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_n    = state;
    armed_n    = armed;
    lvl_cnt_n  = lvl_cnt;
    speed_n    = speed;
    jump_req_n = 1'b0;
    case (state)
      ST_IDLE: begin
        // A score edge must pass before a start so the score counter has cleared
        if (score_edge) armed_n = 1'b1;
        if (btn_press && armed) begin
          state_n = ST_RUN;
          armed_n = 1'b0;
        end
      end
      ST_RUN: begin
        // Collision wins over a simultaneous press
        if (gs.collision) begin
          state_n = ST_OVER;
        end else begin
          jump_req_n = btn_press;
          if (score_edge) begin
            if (lvl_cnt == LVL_W'(LEVEL_TICKS - 1)) begin
              lvl_cnt_n = '0;
              if (speed != SPEED_MAX) speed_n = speed + SPEED_W'(1);
            end else begin
              lvl_cnt_n = lvl_cnt + LVL_W'(1);
            end
          end
        end
      end
      ST_OVER: begin
        if (btn_press) begin
          state_n   = ST_IDLE;
          lvl_cnt_n = '0;
          speed_n   = '0;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign gs.gameState  = state;
  assign gs.scoreClk   = score_clk;
  assign gs.jumpReq    = jump_req;
  assign gs.speedLevel = speed;

endmodule

// File: tb/tb_game_state_controller.sv
// Directed bench for game_state_controller. DUT A uses TICK_DIV=4 for the
// main scenarios; DUT B uses a long score period so a press can land in
// IDLE before the first score edge.
module tb_game_state_controller;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  game_state_controller_if ifa ();
  game_state_controller_if ifb ();

  game_state_controller #(
    .TICK_DIV (4), .DEBOUNCE_CYC (3), .LEVEL_TICKS (2)
  ) dut_a (
    .clk (clk), .rst_n (rst_n), .gs (ifa)
  );

  game_state_controller #(
    .TICK_DIV (64), .DEBOUNCE_CYC (3), .LEVEL_TICKS (2)
  ) dut_b (
    .clk (clk), .rst_n (rst_n), .gs (ifb)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int  bad;
    int  prev;
    int  t;
    int  last_t;
    int  first_t;
    bit  done;
    bit  seen;
    logic prev_s;

    ifa.jumpBtn = 1'b0; ifa.collision = 1'b0;
    ifb.jumpBtn = 1'b0; ifb.collision = 1'b0;

    // Reset state
    tick(2);
    chk("rst_state", 32'(ifa.gameState), 32'd0);
    chk("rst_sclk",  32'(ifa.scoreClk), 32'd0);
    chk("rst_jump",  32'(ifa.jumpReq), 32'd0);
    chk("rst_speed", 32'(ifa.speedLevel), 32'd0);
    rst_n = 1'b1;

    // scoreClk 1,1,0,0 repeating from reset release
    for (int i = 0; i < 8; i++) begin
      tick(1);
      chk($sformatf("sclk_%0d", i), 32'(ifa.scoreClk), ((i % 4) < 2) ? 32'd1 : 32'd0);
    end
    chk("idle_state", 32'(ifa.gameState), 32'd0);
    chk("idle_speed", 32'(ifa.speedLevel), 32'd0);

    // Two-cycle glitch is filtered
    ifa.jumpBtn = 1'b1;
    tick(2);
    ifa.jumpBtn = 1'b0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (ifa.gameState != 2'b00) bad++;
    end
    chk("short_press", 32'(bad), 32'd0);

    // Held press: sync 2 + debounce 3 -> press, RUN on the next edge
    ifa.jumpBtn = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick(1);
      chk($sformatf("run_entry_%0d", i), 32'(ifa.gameState), (i == 6) ? 32'd2 : 32'd0);
    end
    chk("no_jump_on_start", 32'(ifa.jumpReq), 32'd0);
    ifa.jumpBtn = 1'b0;

    // Speed ramps by one every 2 score edges (8 clk) and saturates at 7
    prev = 0; t = 0; last_t = 0; first_t = -1; done = 1'b0;
    while (!done && t < 120) begin
      tick(1);
      t++;
      if (32'(ifa.speedLevel) != prev) begin
        chk("lvl_step", 32'(ifa.speedLevel), prev + 1);
        if (prev == 0) first_t = t;
        else chk("lvl_gap", t - last_t, 32'd8);
        last_t = t;
        prev   = 32'(ifa.speedLevel);
        if (prev == 7) done = 1'b1;
      end
    end
    chk("lvl_reach7", 32'(done), 32'd1);
    chk("lvl_first", 32'(first_t >= 5 && first_t <= 12), 32'd1);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (ifa.speedLevel != 3'd7 || ifa.gameState != 2'b10) bad++;
    end
    chk("lvl_sat", 32'(bad), 32'd0);

    // Press in RUN -> single jumpReq pulse
    ifa.jumpBtn = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick(1);
      chk($sformatf("jump_%0d", i), 32'(ifa.jumpReq), (i == 6) ? 32'd1 : 32'd0);
      if (i == 6) ifa.jumpBtn = 1'b0;
    end
    chk("jump_stay_run", 32'(ifa.gameState), 32'd2);
    tick(8);

    // Collision together with a press -> OVER, no jump
    ifa.jumpBtn = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      tick(1);
      if (i == 5) begin
        chk("pre_coll_run", 32'(ifa.gameState), 32'd2);
        ifa.collision = 1'b1;
      end
      if (i == 6) begin
        chk("coll_over", 32'(ifa.gameState), 32'd1);
        chk("coll_no_jump", 32'(ifa.jumpReq), 32'd0);
        ifa.collision = 1'b0;
        ifa.jumpBtn   = 1'b0;
      end
      if (i == 7) chk("coll_no_jump_late", 32'(ifa.jumpReq), 32'd0);
    end
    chk("over_speed_hold", 32'(ifa.speedLevel), 32'd7);

    // Collision ignored in OVER
    ifa.collision = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk("over_coll_ignored", 32'(ifa.gameState), 32'd1);
    end
    ifa.collision = 1'b0;
    tick(4);

    // Press in OVER -> IDLE with speed cleared
    ifa.jumpBtn = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick(1);
      if (i == 5) begin
        chk("over_before", 32'(ifa.gameState), 32'd1);
        chk("over_speed_7", 32'(ifa.speedLevel), 32'd7);
      end
      if (i == 6) begin
        chk("over_to_idle", 32'(ifa.gameState), 32'd0);
        chk("idle_speed_clr", 32'(ifa.speedLevel), 32'd0);
      end
    end
    ifa.jumpBtn = 1'b0;

    // DUT B: RUN, then OVER
    ifb.jumpBtn = 1'b1;
    tick(6);
    chk("b_run", 32'(ifb.gameState), 32'd2);
    ifb.jumpBtn = 1'b0;
    tick(8);
    ifb.collision = 1'b1;
    tick(1);
    ifb.collision = 1'b0;
    chk("b_over", 32'(ifb.gameState), 32'd1);
    tick(6);

    // Align to a scoreClk rise so IDLE is entered well before the next edge
    seen = 1'b0;
    prev_s = ifb.scoreClk;
    for (int k = 0; k < 200 && !seen; k++) begin
      tick(1);
      if (!prev_s && ifb.scoreClk) seen = 1'b1;
      prev_s = ifb.scoreClk;
    end
    chk("b_align", 32'(seen), 32'd1);
    ifb.jumpBtn = 1'b1;
    tick(6);
    chk("b_idle", 32'(ifb.gameState), 32'd0);
    ifb.jumpBtn = 1'b0;
    tick(6);

    // Press before the first score edge in IDLE is ignored
    ifb.jumpBtn = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (ifb.gameState != 2'b00) bad++;
    end
    chk("b_unarmed_ignored", 32'(bad), 32'd0);
    ifb.jumpBtn = 1'b0;

    // After a score edge the next press starts the game
    seen = 1'b0;
    prev_s = ifb.scoreClk;
    for (int k = 0; k < 200 && !seen; k++) begin
      tick(1);
      if (!prev_s && ifb.scoreClk) seen = 1'b1;
      prev_s = ifb.scoreClk;
    end
    chk("b_edge_seen", 32'(seen), 32'd1);
    tick(2);
    ifb.jumpBtn = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick(1);
      chk($sformatf("b_armed_run_%0d", i), 32'(ifb.gameState), (i == 6) ? 32'd2 : 32'd0);
    end
    ifb.jumpBtn = 1'b0;

    // DUT A: restart, reach speed 3, then asynchronous reset
    ifa.jumpBtn = 1'b1;
    tick(6);
    chk("a_rerun", 32'(ifa.gameState), 32'd2);
    ifa.jumpBtn = 1'b0;
    t = 0;
    while (ifa.speedLevel != 3'd3 && t < 100) begin
      tick(1);
      t++;
    end
    chk("a_lvl3", 32'(ifa.speedLevel), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_state", 32'(ifa.gameState), 32'd0);
    chk("async_sclk",  32'(ifa.scoreClk), 32'd0);
    chk("async_jump",  32'(ifa.jumpReq), 32'd0);
    chk("async_speed", 32'(ifa.speedLevel), 32'd0);
    tick(2);
    rst_n = 1'b1;

    // First post-reset press needs the full debounce
    ifa.jumpBtn = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick(1);
      chk($sformatf("post_rst_%0d", i), 32'(ifa.gameState), (i == 6) ? 32'd2 : 32'd0);
    end
    ifa.jumpBtn = 1'b0;
    tick(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
